// File: rtl/branch_resolve_pkg.sv
// Purpose: shared types, FSM encodings and the A64 condition evaluator for branch resolution.
// Latency: none; declarations and a pure combinational helper only.
// Backpressure: none.
package branch_resolve_pkg;

  typedef enum logic [1:0] {
    BR_COND     = 2'd0,
    BR_UNCOND   = 2'd1,
    BR_INDIRECT = 2'd2,
    BR_NOP      = 2'd3
  } br_kind_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_t;

  // Kept as plain constants so legacy code can compare raw state bits.
  typedef logic [1:0] resolve_state_t;
  localparam resolve_state_t RESET_WAIT = 2'd0;
  localparam resolve_state_t START      = 2'd1;
  localparam resolve_state_t RUN        = 2'd2;
  localparam resolve_state_t FAR        = 2'd3;

  // A64 codes come in true/inverted pairs: bits [3:1] pick the base test and
  // bit 0 inverts it, except 1111 (NV) which behaves as always.
  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, base;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return (cond[0] && (cond != 4'hF)) ? ~base : base;
  endfunction

endpackage

// File: rtl/branch_resolve.sv
// Purpose: resolves executed branches, trains the predictor and issues redirects (near or two-cycle far).
// Latency: accepted branch shows on outputs one edge later; a far redirect follows one further edge.
// Backpressure: ex_ready is low outside RUN (reset wait, start pulse, far cycle); unaccepted branches are ignored.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int          START_DELAY = 2,
  parameter int          OFF_W       = 19
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic [63:0]      ex_pc,
  input  logic [1:0]       ex_kind,
  input  logic [3:0]       ex_cond,
  input  logic [3:0]       ex_nzcv,
  input  logic [63:0]      ex_target,
  input  logic             ex_pred_taken,
  input  logic [63:0]      ex_pred_target,
  input  logic             ex_epoch,
  output logic             x_bcond_resolved,
  output logic             x_taken,
  output logic [63:0]      x_pc,
  output logic             x_pc_incorrect,
  output logic [OFF_W-1:0] x_correction_offset,
  output logic             start_signal,
  output logic [63:0]      start_pc,
  output logic             epoch_out,
  output logic             flush_out
);

  localparam int CW = (START_DELAY < 1) ? 1 : $clog2(START_DELAY + 1);

  resolve_state_t state;
  logic [CW-1:0]  wait_cnt;
  logic           epoch;
  logic [63:0]    far_target;

  logic [63:0] seq_pc, actual, predicted, diff;
  logic        taken, mispredict, fits, live;

  assign ex_ready  = (state == RUN);
  assign start_pc  = RESET_PC;
  assign epoch_out = epoch;

  // Architectural outcome, prediction check and whether the correction fits the offset field.
  always_comb begin
    seq_pc     = ex_pc + 64'd4;
    taken      = (ex_kind == BR_COND) ? cond_holds(ex_cond, ex_nzcv) : 1'b1;
    actual     = taken ? ex_target : seq_pc;
    predicted  = ex_pred_taken ? ex_pred_target : seq_pc;
    mispredict = (actual != predicted);
    diff       = actual - ex_pc;
    fits       = ({{(64-OFF_W){diff[OFF_W-1]}}, diff[OFF_W-1:0]} == diff);
    live       = ex_valid && ex_ready && (ex_epoch == epoch) && (ex_kind != BR_NOP);
  end

  // Start sequencing, resolution FSM and the registered predictor/redirect outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state               <= RESET_WAIT;
      wait_cnt            <= '0;
      epoch               <= 1'b0;
      far_target          <= '0;
      x_bcond_resolved    <= 1'b0;
      x_taken             <= 1'b0;
      x_pc                <= '0;
      x_pc_incorrect      <= 1'b0;
      x_correction_offset <= '0;
      start_signal        <= 1'b0;
      flush_out           <= 1'b0;
    end else begin
      x_bcond_resolved <= 1'b0;
      x_pc_incorrect   <= 1'b0;
      flush_out        <= 1'b0;
      start_signal     <= 1'b0;
      case (state)
        RESET_WAIT: begin
          if (wait_cnt == CW'(START_DELAY)) begin
            state               <= START;
            start_signal        <= 1'b1;
            x_pc                <= RESET_PC;
            x_correction_offset <= '0;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        START: state <= RUN;
        RUN: begin
          if (live) begin
            x_pc             <= ex_pc;
            x_taken          <= taken;
            x_bcond_resolved <= (ex_kind == BR_COND);
            if (mispredict) begin
              if (fits) begin
                x_pc_incorrect      <= 1'b1;
                flush_out           <= 1'b1;
                x_correction_offset <= diff[OFF_W-1:0];
                epoch               <= ~epoch;
              end else begin
                // Too far for the offset field: redirect from an absolute base next cycle.
                far_target <= actual;
                state      <= FAR;
              end
            end
          end
        end
        FAR: begin
          x_pc                <= far_target;
          x_correction_offset <= '0;
          x_pc_incorrect      <= 1'b1;
          flush_out           <= 1'b1;
          epoch               <= ~epoch;
          state               <= RUN;
        end
        default: state <= RESET_WAIT;
      endcase
    end
  end

endmodule
